mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single tagged memory port between the icache fetch path and the dcache.
- Selects one requester per cycle and forwards its command, address and data to memory.
- Returns the memory's issue response (the transaction tag, 0 = rejected) only to the granted requester.
- Records which requester owns each in-flight tag, so each returning data beat is delivered only to the requester that issued it.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles icache may be denied while requesting before it is forced to win.
- NUM_TAGS, 16: size of the memory tag space; tag 0 is reserved as "none".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clock)
- icache_command  in  2  BUS_NONE/BUS_LOAD from the icache
- icache_addr  in  XLEN  icache request address, 8-byte aligned
- dcache_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from the dcache
- dcache_addr  in  XLEN  dcache request address
- dcache_data  in  64  store data
- dcache_lock  in  1  dcache holds priority across consecutive cycles (eviction, then refill)
- mem2proc_response  in  4  memory issue tag, 0 = not accepted
- mem2proc_tag  in  4  tag of the returning data beat, 0 = none
- mem2proc_data  in  64  returning data
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  XLEN  address to memory
- proc2mem_data  out  64  store data to memory
- icache_response  out  4  issue tag to icache, 0 when it is not granted or not accepted
- icache_tag  out  4  returning tag routed to icache, 0 otherwise
- dcache_response  out  4  issue tag to dcache
- dcache_tag  out  4  returning tag routed to dcache
- mem_data_out  out  64  mem2proc_data, broadcast to both requesters
- icache_granted  out  1  icache owns the bus this cycle

Behaviour:
- Grant is combinational from current state and requests.
  - Default priority: dcache over icache.
  - icache wins if dcache_command==BUS_NONE.
  - icache also wins if starve_cnt==STARVE_LIMIT and dcache_lock==0.
  - dcache_lock==1 with dcache requesting always grants dcache and overrides starvation.
- Forwarding: proc2mem_* carry the granted requester's fields. With no request: BUS_NONE, addr 0, data 0.
- Issue response: the granted requester's *_response = mem2proc_response; the other requester's response = 0.
- Owner table: NUM_TAGS entries, each holding valid plus owner (0 = icache, 1 = dcache).
  - Written on posedge when the granted command is BUS_LOAD and mem2proc_response != 0.
  - BUS_STORE responses are not recorded, because stores return no data.
- Data routing:
  - When mem2proc_tag != 0 and entry[mem2proc_tag] is valid, drive the owner's *_tag = mem2proc_tag and the other requester's *_tag = 0.
  - Clear the entry on the same posedge.
  - A returning tag that is not valid is dropped: both *_tag = 0 and the orphan_tag flag pulses in the perf block.
  - A tag retiring and the same tag re-issuing in the same cycle: the write wins; the entry ends valid with the new owner.
- Starvation counter (3 bits, saturating at STARVE_LIMIT):
  - Increments when icache requests and dcache is granted.
  - Clears when icache is granted or icache_command==BUS_NONE.
  - A grant that memory rejects (response 0) still counts as a grant.
- Zero-latency path: all outputs are combinational from state and inputs. State updates only on posedge.
- Reset (reset==0):
  - Owner table all invalid; starve_cnt = 0.
  - All outputs forced to 0 / BUS_NONE during reset, regardless of inputs.
  - Reset mid-transaction drops all outstanding ownership. Late returning tags are then treated as orphans and dropped.

Optional Feature:
- MEM_ARB_PERF_EN
- When defined, adds outputs perf_icache_grants, perf_dcache_grants, perf_stall_cycles and perf_orphans (32 bits each, saturating).
  - perf_icache_grants / perf_dcache_grants count accepted issues per requester.
  - perf_stall_cycles counts cycles in which icache requested but was not granted.
  - perf_orphans counts dropped returning tags.
  - All counters clear on reset.
- When undefined, these ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- Shared package (sys_defs) holds:
  - existing BUS_NONE/BUS_LOAD/BUS_STORE encoding;
  - MEM_TAG_W = 4;
  - typedef REQ_OWNER {OWN_ICACHE, OWN_DCACHE};
  - typedef tag_entry_t {valid, owner}.
- One natural sub-module: mem_tag_owner_table, holding table write/clear and the lookup port. Grant logic stays in the top module.

Test Plan:
- Both request; dcache LOAD 0x100, icache LOAD 0x200; memory response 3 -> dcache_response=3, icache_response=0; later mem2proc_tag=3 -> dcache_tag=3, icache_tag=0.
- icache only, LOAD 0x40; response 5 -> icache_granted=1, proc2mem_addr=0x40; tag 5 returns three cycles later -> icache_tag=5.
- dcache requests every cycle and icache is held on -> icache is granted on cycle 5 (STARVE_LIMIT=4). With dcache_lock=1 held throughout -> icache never granted.
- dcache STORE 0x80 with data 0xDEAD_BEEF; response 7 -> proc2mem_data matches; a later mem2proc_tag=7 is an orphan -> both *_tag=0.
- Same-cycle retire and re-issue of tag 2: icache tag 2 returns while dcache is issued tag 2 -> icache_tag=2, and the next return of tag 2 routes to dcache.
- Reset asserted (reset=0) with tags 1 and 4 outstanding -> outputs are BUS_NONE/0; after release, returning tags 1 and 4 are dropped.

Source files
------------

// File: rtl/sys_defs.sv
// Shared bus encodings, tag width and tag-ownership types for the memory arbiter.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } REQ_OWNER;

  typedef struct packed {
    logic     valid;
    REQ_OWNER owner;
  } tag_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag ownership record: which requester issued each in-flight memory tag.
// Combinational lookup; a write to a tag takes precedence over a same-cycle clear.
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MEM_TAG_W-1:0] wr_tag,
  input  REQ_OWNER             wr_owner,
  input  logic                 clr_en,
  input  logic [MEM_TAG_W-1:0] clr_tag,
  input  logic [MEM_TAG_W-1:0] rd_tag,
  output tag_entry_t           rd_entry
);

  logic [NUM_TAGS-1:0] valid_vec;
  logic [NUM_TAGS-1:0] owner_vec;

  generate
    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      tag_entry_t entry_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          entry_reg <= '{valid: 1'b0, owner: OWN_ICACHE};
        end else if (wr_en && (wr_tag == MEM_TAG_W'(gi))) begin
          entry_reg <= '{valid: 1'b1, owner: wr_owner};
        end else if (clr_en && (clr_tag == MEM_TAG_W'(gi))) begin
          entry_reg.valid <= 1'b0;
        end
      end

      assign valid_vec[gi] = entry_reg.valid;
      assign owner_vec[gi] = entry_reg.owner;
    end
  endgenerate

  always_comb begin
    rd_entry.valid = valid_vec[rd_tag];
    rd_entry.owner = REQ_OWNER'(owner_vec[rd_tag]);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the tagged memory port between icache and dcache and routes returning tags.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           icache_command,
  input  logic [XLEN-1:0]      icache_addr,
  input  logic [1:0]           dcache_command,
  input  logic [XLEN-1:0]      dcache_addr,
  input  logic [63:0]          dcache_data,
  input  logic                 dcache_lock,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]          mem2proc_data,
  output logic [1:0]           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  output logic [MEM_TAG_W-1:0] icache_response,
  output logic [MEM_TAG_W-1:0] icache_tag,
  output logic [MEM_TAG_W-1:0] dcache_response,
  output logic [MEM_TAG_W-1:0] dcache_tag,
  output logic [63:0]          mem_data_out,
  output logic                 icache_granted
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_icache_grants,
  output logic [31:0]          perf_dcache_grants,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_orphans
`endif
);

  logic       icache_req;
  logic       dcache_req;
  logic       grant_icache;
  logic       grant_dcache;
  logic [1:0] granted_cmd;
  logic       tbl_wr_en;
  REQ_OWNER   tbl_wr_owner;
  logic       tag_hit;
  tag_entry_t rd_entry;
  logic [2:0] starve_cnt_reg;
  logic [2:0] starve_cnt_next;

  assign icache_req = (icache_command != BUS_NONE);
  assign dcache_req = (dcache_command != BUS_NONE);

  // A locked dcache beats starvation; otherwise a starved icache wins once.
  always_comb begin
    grant_icache = 1'b0;
    grant_dcache = 1'b0;
    if (dcache_req &&
        (dcache_lock || !(icache_req && (starve_cnt_reg == 3'(STARVE_LIMIT))))) begin
      grant_dcache = 1'b1;
    end else if (icache_req) begin
      grant_icache = 1'b1;
    end
  end

  always_comb begin
    granted_cmd = BUS_NONE;
    if (grant_dcache) begin
      granted_cmd = dcache_command;
    end else if (grant_icache) begin
      granted_cmd = icache_command;
    end
  end

  assign tbl_wr_en    = reset && (granted_cmd == BUS_LOAD) && (mem2proc_response != '0);
  assign tbl_wr_owner = grant_dcache ? OWN_DCACHE : OWN_ICACHE;
  assign tag_hit      = reset && (mem2proc_tag != '0) && rd_entry.valid;

  mem_tag_owner_table #(
    .NUM_TAGS(NUM_TAGS)
  ) u_owner_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (tbl_wr_en),
    .wr_tag   (mem2proc_response),
    .wr_owner (tbl_wr_owner),
    .clr_en   (tag_hit),
    .clr_tag  (mem2proc_tag),
    .rd_tag   (mem2proc_tag),
    .rd_entry (rd_entry)
  );

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    icache_response  = '0;
    icache_tag       = '0;
    dcache_response  = '0;
    dcache_tag       = '0;
    mem_data_out     = '0;
    icache_granted   = 1'b0;
    if (reset) begin
      mem_data_out   = mem2proc_data;
      icache_granted = grant_icache;
      if (grant_dcache) begin
        proc2mem_command = dcache_command;
        proc2mem_addr    = dcache_addr;
        proc2mem_data    = dcache_data;
        dcache_response  = mem2proc_response;
      end else if (grant_icache) begin
        proc2mem_command = icache_command;
        proc2mem_addr    = icache_addr;
        icache_response  = mem2proc_response;
      end
      if (tag_hit) begin
        if (rd_entry.owner == OWN_DCACHE) begin
          dcache_tag = mem2proc_tag;
        end else begin
          icache_tag = mem2proc_tag;
        end
      end
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!icache_req || grant_icache) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg < 3'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic        issue_accepted;
  logic        orphan_tag;
  logic [31:0] perf_icache_grants_reg;
  logic [31:0] perf_dcache_grants_reg;
  logic [31:0] perf_stall_cycles_reg;
  logic [31:0] perf_orphans_reg;

  assign issue_accepted = (granted_cmd != BUS_NONE) && (mem2proc_response != '0);
  assign orphan_tag     = (mem2proc_tag != '0) && !rd_entry.valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_icache_grants_reg <= '0;
      perf_dcache_grants_reg <= '0;
      perf_stall_cycles_reg  <= '0;
      perf_orphans_reg       <= '0;
    end else begin
      if (issue_accepted && grant_icache) begin
        perf_icache_grants_reg <= sat_inc32(perf_icache_grants_reg);
      end
      if (issue_accepted && grant_dcache) begin
        perf_dcache_grants_reg <= sat_inc32(perf_dcache_grants_reg);
      end
      if (icache_req && !grant_icache) begin
        perf_stall_cycles_reg <= sat_inc32(perf_stall_cycles_reg);
      end
      if (orphan_tag) begin
        perf_orphans_reg <= sat_inc32(perf_orphans_reg);
      end
    end
  end

  assign perf_icache_grants = reset ? perf_icache_grants_reg : '0;
  assign perf_dcache_grants = reset ? perf_dcache_grants_reg : '0;
  assign perf_stall_cycles  = reset ? perf_stall_cycles_reg  : '0;
  assign perf_orphans       = reset ? perf_orphans_reg       : '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  iresp;
    logic [3:0]  itag;
    logic [3:0]  dresp;
    logic [3:0]  dtag;
    logic [63:0] mdata;
    logic        igrant;
  } out_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache_command;
  logic [31:0] icache_addr;
  logic [1:0]  dcache_command;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_data;
  logic        dcache_lock;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  icache_response;
  logic [3:0]  icache_tag;
  logic [3:0]  dcache_response;
  logic [3:0]  dcache_tag;
  logic [63:0] mem_data_out;
  logic        icache_granted;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_icache_grants;
  logic [31:0] perf_dcache_grants;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_orphans;
`endif

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .icache_command    (icache_command),
    .icache_addr       (icache_addr),
    .dcache_command    (dcache_command),
    .dcache_addr       (dcache_addr),
    .dcache_data       (dcache_data),
    .dcache_lock       (dcache_lock),
    .mem2proc_response (mem2proc_response),
    .mem2proc_tag      (mem2proc_tag),
    .mem2proc_data     (mem2proc_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .icache_response   (icache_response),
    .icache_tag        (icache_tag),
    .dcache_response   (dcache_response),
    .dcache_tag        (dcache_tag),
    .mem_data_out      (mem_data_out),
    .icache_granted    (icache_granted)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_icache_grants (perf_icache_grants),
    .perf_dcache_grants (perf_dcache_grants),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_orphans       (perf_orphans)
`endif
  );

  function automatic out_t mk(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                              input logic [3:0] ir, input logic [3:0] it, input logic [3:0] dr,
                              input logic [3:0] dt, input logic [63:0] md, input logic g);
    out_t o;
    o = '{cmd: c, addr: a, data: d, iresp: ir, itag: it, dresp: dr, dtag: dt, mdata: md, igrant: g};
    return o;
  endfunction

  task automatic set_in(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                        input logic [31:0] da, input logic [63:0] dd, input logic lk,
                        input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    icache_command    = ic;
    icache_addr       = ia;
    dcache_command    = dc;
    dcache_addr       = da;
    dcache_data       = dd;
    dcache_lock       = lk;
    mem2proc_response = rsp;
    mem2proc_tag      = tg;
    mem2proc_data     = md;
  endtask

  task automatic step(input string nm, input out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    out_t  e;
    out_t  act;
    string nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = '{cmd: proc2mem_command, addr: proc2mem_addr, data: proc2mem_data,
              iresp: icache_response, itag: icache_tag, dresp: dcache_response,
              dtag: dcache_tag, mdata: mem_data_out, igrant: icache_granted};
      n_checks++;
      if (act === e) begin
        n_pass++;
        $display("check %s ok: %h", nm, act);
      end else begin
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    out_t zero;
    zero  = '0;
    reset = 1'b0;
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;

    // Reset forces all outputs low even with live inputs
    set_in(BUS_LOAD, 32'h40, BUS_STORE, 32'h80, 64'hDEAD, 1'b1, 4'd5, 4'd3, 64'h55);
    step("reset_a", zero);
    step("reset_b", zero);
    reset = 1'b1;

    set_in(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h0, 1'b0, 4'd3, 4'd0, 64'h0);
    step("both_req", mk(BUS_LOAD, 32'h100, 64'h0, 4'd0, 4'd0, 4'd3, 4'd0, 64'h0, 1'b0));
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd3, 64'h1111);
    step("dret3", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd3, 64'h1111, 1'b0));

    set_in(BUS_LOAD, 32'h40, BUS_NONE, 0, 0, 1'b0, 4'd5, 4'd0, 64'h0);
    step("ic_only", mk(BUS_LOAD, 32'h40, 64'h0, 4'd5, 4'd0, 4'd0, 4'd0, 64'h0, 1'b1));
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd0, 64'h0);
    step("idle1", zero);
    step("idle2", zero);
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd5, 64'h2222);
    step("iret5", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd5, 4'd0, 4'd0, 64'h2222, 1'b0));

    // Starvation: four dcache wins, then icache forced through (rejected grants still count)
    set_in(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'h0, 1'b0, 4'd0, 4'd0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step("starve_d", mk(BUS_LOAD, 32'h300, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 1'b0));
    end
    step("starve_i", mk(BUS_LOAD, 32'h200, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 1'b1));

    set_in(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'h0, 1'b1, 4'd0, 4'd0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      step("lock_d", mk(BUS_LOAD, 32'h300, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 1'b0));
    end
    dcache_lock = 1'b0;
    step("unlock_i", mk(BUS_LOAD, 32'h200, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 1'b1));

    set_in(BUS_NONE, 0, BUS_STORE, 32'h80, 64'hDEAD_BEEF, 1'b0, 4'd7, 4'd0, 64'h0);
    step("store", mk(BUS_STORE, 32'h80, 64'hDEAD_BEEF, 4'd0, 4'd0, 4'd7, 4'd0, 64'h0, 1'b0));
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd7, 64'h3333);
    step("orphan7", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h3333, 1'b0));

    // Tag 2 retires to icache while being reissued to dcache
    set_in(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 1'b0, 4'd2, 4'd0, 64'h0);
    step("ic_t2", mk(BUS_LOAD, 32'h500, 64'h0, 4'd2, 4'd0, 4'd0, 4'd0, 64'h0, 1'b1));
    set_in(BUS_NONE, 0, BUS_LOAD, 32'h600, 64'h0, 1'b0, 4'd2, 4'd2, 64'h4444);
    step("retire_reissue", mk(BUS_LOAD, 32'h600, 64'h0, 4'd0, 4'd2, 4'd2, 4'd0, 64'h4444, 1'b0));
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd2, 64'h5555);
    step("dret2", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd2, 64'h5555, 1'b0));
    step("orphan2", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h5555, 1'b0));

    set_in(BUS_LOAD, 32'h700, BUS_NONE, 0, 0, 1'b0, 4'd1, 4'd0, 64'h0);
    step("ic_t1", mk(BUS_LOAD, 32'h700, 64'h0, 4'd1, 4'd0, 4'd0, 4'd0, 64'h0, 1'b1));
    set_in(BUS_NONE, 0, BUS_LOAD, 32'h740, 64'h0, 1'b0, 4'd4, 4'd0, 64'h0);
    step("dc_t4", mk(BUS_LOAD, 32'h740, 64'h0, 4'd0, 4'd0, 4'd4, 4'd0, 64'h0, 1'b0));
    reset = 1'b0;
    set_in(BUS_LOAD, 32'h800, BUS_LOAD, 32'h840, 64'h9, 1'b1, 4'd6, 4'd1, 64'h6666);
    step("reset_mid", zero);
    reset = 1'b1;
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd1, 64'h7777);
    step("late1", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h7777, 1'b0));
    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd4, 64'h8888);
    step("late4", mk(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h8888, 1'b0));

    set_in(BUS_NONE, 0, BUS_NONE, 0, 0, 1'b0, 4'd0, 4'd0, 64'h0);
    repeat (2) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
